// File: rtl/e_clock_gen.sv
// E clock generator and VPA/VMA synchronous-peripheral handshake.
// A free-running divider produces E. A small FSM aligns peripheral
// transfers to the E period so that vma_n brackets the E-high phase.
module e_clock_gen #(
  parameter int unsigned E_LOW  = 6,
  parameter int unsigned E_HIGH = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             as_n,
  input  logic             vpa_n,
  output logic             e,
  output logic             vma_n,
  output logic [CNT_W-1:0] e_phase,
  output logic             cycle_done,
  output logic             busy
);

  localparam int unsigned PERIOD = E_LOW + E_HIGH;

  // Last phase before wrap, first E-high phase, and the phase at which a
  // pending request commits so vma_n leads E rising by two clocks.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(E_LOW);
  localparam logic [CNT_W-1:0] CNT_SYNC = CNT_W'(E_LOW - 3);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    ASSERT,
    HOLD
  } state_t;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap_c;

  logic             as_r;
  logic             vpa_r;

  state_t           state;
  state_t           state_nxt;
  logic             vma_n_nxt;
  logic             done_nxt;
  logic             busy_nxt;

  // Phase counter next value; wraps at the end of the E period.
  always_comb begin
    wrap_c  = (cnt == CNT_LAST);
    cnt_nxt = wrap_c ? '0 : cnt + CNT_W'(1);
  end

  // Free-running divider; e is registered so it lines up with cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      e   <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      e   <= (cnt_nxt >= CNT_RISE);
    end
  end

  assign e_phase = cnt;

  // Bus inputs registered in asserted-true sense.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      as_r  <= 1'b0;
      vpa_r <= 1'b0;
    end else begin
      as_r  <= ~as_n;
      vpa_r <= ~vpa_n;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output logic; abort on as_r low beats the wrap.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    vma_n_nxt = 1'b1;
    busy_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (as_r && vpa_r) begin
          state_nxt = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        if (!as_r) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_SYNC) begin
          state_nxt = ASSERT;
        end
      end
      ASSERT: begin
        if (!as_r) begin
          state_nxt = IDLE;
        end else if (wrap_c) begin
          state_nxt = HOLD;
          done_nxt  = 1'b1;
        end
      end
      HOLD: begin
        if (!as_r) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    vma_n_nxt = (state_nxt != ASSERT);
    busy_nxt  = (state_nxt != IDLE);
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vma_n      <= 1'b1;
      cycle_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vma_n      <= vma_n_nxt;
      cycle_done <= done_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: doc/e_clock_gen.md
Name: e_clock_gen

Overview:
- Generates the 6800-style E clock and runs the VPA/VMA synchronous-peripheral handshake for 68000 bus cycles.
- Sits directly upstream of the bus error watchdog: the watchdog consumes e together with the CPU address strobe.
- Also drives vma_n to 6800-family peripherals (ACIA, PIA).
- Free-running E divider plus a small handshake FSM, all in the single clk domain.

Parameters:
E_LOW, 6, clk cycles E is low per period (must be >= 3)
E_HIGH, 4, clk cycles E is high per period (must be >= 1)
CNT_W, 4, width of phase counter; must hold E_LOW+E_HIGH-1

Ports:
clk  input  1  CPU clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
as_n  input  1  CPU address strobe, active low, synchronous to clk
vpa_n  input  1  valid peripheral address from address decoder, active low
e  output  1  E clock to peripherals and the bus error watchdog
vma_n  output  1  valid memory address to peripherals, active low
e_phase  output  CNT_W  current E phase counter value
cycle_done  output  1  one-clk pulse: peripheral transfer completed
busy  output  1  handshake FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: e=0, vma_n=1, e_phase=0, cycle_done=0, busy=0.
  - FSM=IDLE; input registers as_r=0 and vpa_r=0 (asserted-true sense).
- E divider:
  - Free-running counter cnt runs 0..E_LOW+E_HIGH-1, then wraps to 0. It never stalls and ignores bus activity.
  - e is registered: e=1 exactly when cnt >= E_LOW.
  - Defaults give period 10, low 6, high 4. e_phase = cnt.
- Inputs: as_r <= ~as_n and vpa_r <= ~vpa_n every clk. The FSM uses only these registered values, so there is 1 clk input latency.
- FSM states IDLE, WAIT_SYNC, ASSERT, HOLD:
  - IDLE: if as_r & vpa_r -> WAIT_SYNC.
  - WAIT_SYNC: if ~as_r -> IDLE (abort). Else if cnt == E_LOW-3 -> ASSERT. A request already pending when cnt==E_LOW-3 goes immediately; otherwise it waits for the next occurrence.
  - ASSERT: vma_n=0, registered, so it is low from the clk after the transition.
    - If ~as_r -> IDLE: vma_n=1 next clk, no cycle_done.
    - Else, on the edge where cnt wraps to 0 (E falling) -> HOLD, with vma_n=1 and cycle_done=1 for that one clk.
  - HOLD: wait for ~as_r -> IDLE. This prevents a second handshake within the same bus cycle.
- With defaults, vma_n is low for cnt=4..9: 2 clks before E rises through the full E-high phase, 6 clks total. The transfer is bracketed by E high.
- busy=1 in every state except IDLE. cycle_done is never asserted outside the ASSERT->HOLD transition.
- Simultaneous events:
  - Abort (as_r=0) has priority over the wrap transition in ASSERT.
  - as_r and vpa_r both rising in IDLE on the same clk as cnt==E_LOW-3 still only enters WAIT_SYNC; ASSERT follows one E period later.
- vpa_n deasserting after WAIT_SYNC is entered does not abort the handshake; only as_n abort counts (the CPU owns the cycle).
- Reset asserted mid-handshake: vma_n returns to 1 immediately (async), with no cycle_done pulse.

Test Plan:
- Reset release, no bus activity:
  - e period 10 clks (low 6, high 4); e_phase runs 0..9 and wraps.
  - vma_n stays 1, busy=0, for 100 clks.
- as_n=0, vpa_n=0 presented so that as_r and vpa_r are both 1 at cnt=5:
  - FSM goes IDLE -> WAIT_SYNC, then waits for the next cnt=3.
  - vma_n is low during cnt=4..9; cycle_done=1 only at cnt=0; then HOLD.
  - as_n high -> busy=0 two clks later.
- Request registered exactly at cnt=3:
  - Only WAIT_SYNC is entered; vma_n asserts at cnt=4 of the following E period, not the current one.
- as_n released at cnt=6 while vma_n is low:
  - vma_n=1 at cnt=8 (1 clk input latency + 1 clk FSM); FSM=IDLE.
  - No cycle_done pulse; e unaffected.
- rst_n pulsed low at cnt=7 during ASSERT:
  - Immediately e=0, vma_n=1, e_phase=0, busy=0.
  - After release, E restarts from phase 0.
- Parameter override E_LOW=3, E_HIGH=2:
  - Period 5, e high at cnt=3..4.
  - A request asserts vma_n at cnt=1..4; cycle_done at cnt=0.
